// File: rtl/dsd_mem_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Holds the FSM state encoding, the requester port indices and the
// default address/data widths used by mem_port_arbiter and arb_pick.
package dsd_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Wide enough for the largest legal memory latency (7).
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the fetch and data ports.
// Ports:
//   req[1:0]    - pending requests, bit 0 = fetch port, bit 1 = data port
//   last_grant  - index of the port granted most recently
//   grant_valid - high when at least one request is pending
//   grant_idx   - index of the winning port (meaningful when grant_valid)
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin between the two
// ports on contention; without it the data port always has priority.
module arb_pick
  import dsd_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  assign grant_valid = |req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On contention give the grant to whichever port did not win last time.
  always_comb begin
    grant_idx = PORT_FETCH;
    if (req[PORT_DATA] && req[PORT_FETCH]) begin
      grant_idx = ~last_grant;
    end else if (req[PORT_DATA]) begin
      grant_idx = PORT_DATA;
    end
  end
`else
  // Fixed priority: history is not needed for the decision.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_idx = req[PORT_DATA] ? PORT_DATA : PORT_FETCH;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port data memory between the instruction-fetch port (0)
// and the load/store port (1). One request is served at a time: the winner's
// command is latched in IDLE, issued to memory for exactly one cycle, and for
// reads the data is captured after MEM_LATENCY cycles. Completion is signalled
// by a one-cycle ack. All outputs are registered.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   pN_req/we/addr/wdata  - request handshake and command for port N
//   pN_ack, pN_rdata      - completion pulse and read data for port N
//   mem_*                 - memory strobes, address, write data, read data
//   busy                  - high whenever the FSM is not in IDLE
// Build option: MEM_ARB_ROUND_ROBIN_EN (see arb_pick) selects round-robin
// arbitration; the default build uses fixed priority for port 1.
module mem_port_arbiter
  import dsd_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state;
  logic               last_grant;
  logic               winner;
  logic               cmd_we;
  logic [CNT_W-1:0]   lat_cnt;

  logic               grant_valid;
  logic               grant_idx;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  arb_pick u_arb_pick (
    .req         ({p1_req, p0_req}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_we    = (grant_idx == PORT_DATA) ? p1_we    : p0_we;
  assign sel_addr  = (grant_idx == PORT_DATA) ? p1_addr  : p0_addr;
  assign sel_wdata = (grant_idx == PORT_DATA) ? p1_wdata : p0_wdata;

  // mem_address/mem_write_data double as the latched command fields, so they
  // stay stable from ISSUE through WAIT and RESP without separate copies.
  // Enables are set on the IDLE->ISSUE edge so they are high only in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      last_grant       <= PORT_DATA;
      winner           <= PORT_FETCH;
      cmd_we           <= 1'b0;
      lat_cnt          <= '0;
      p0_ack           <= 1'b0;
      p1_ack           <= 1'b0;
      p0_rdata         <= '0;
      p1_rdata         <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      busy             <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            winner           <= grant_idx;
            last_grant       <= grant_idx;
            cmd_we           <= sel_we;
            mem_address      <= sel_addr;
            mem_write_data   <= sel_wdata;
            mem_write_enable <= sel_we;
            mem_read_enable  <= ~sel_we;
            busy             <= 1'b1;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_write_enable <= 1'b0;
          mem_read_enable  <= 1'b0;
          if (cmd_we) begin
            if (winner == PORT_DATA) p1_ack <= 1'b1;
            else                     p0_ack <= 1'b1;
            state <= ST_RESP;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - CNT_ONE;
          // Count of 1 marks the cycle in which the memory data is valid.
          if (lat_cnt == CNT_ONE) begin
            if (winner == PORT_DATA) begin
              p1_rdata <= mem_read_data;
              p1_ack   <= 1'b1;
            end else begin
              p0_rdata <= mem_read_data;
              p0_ack   <= 1'b1;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters: port 0 (instruction fetch) and port 1 (load/store data path).
- Sits between the CPU controller and the memory.
- Accepts one request at a time over a req/ack handshake and sequences the memory's enables, address and write data.
- For reads, waits the memory latency, captures read data and returns it with a one-cycle ack.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width (signed data, passed through unmodified).
- MEM_LATENCY, 1, cycles from the read command cycle until mem_read_data is valid; legal range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held high with command fields stable until p0_ack.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p0_rdata  out  DATA_W  port 0 read data; valid while p0_ack is high.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as the p0_* ports, for port 1.
- mem_write_enable  out  1  memory write strobe.
- mem_read_enable  out  1  memory read strobe.
- mem_address  out  ADDR_W  memory address.
- mem_write_data  out  DATA_W  memory write data.
- mem_read_data  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, both acks 0, both rdata 0, both mem enables 0, mem_address 0, mem_write_data 0, busy 0, last_grant 1, latency counter 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select a winner, latch its we/addr/wdata and the winner index, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_address and mem_write_data are driven from the latched values.
  - Exactly one enable is high for exactly this one cycle: write enable if we=1, read enable otherwise.
  - A write goes to RESP.
  - A read loads the counter with MEM_LATENCY and goes to WAIT.
- WAIT:
  - Both enables are 0 and mem_address is held.
  - The counter decrements each cycle.
  - On the cycle the counter reaches 1, mem_read_data is captured into the winner's rdata register and the state moves to RESP.
- RESP:
  - The winner's ack is high for one cycle; the other port's ack stays 0.
  - The next state is IDLE, and requests are not sampled in RESP.
- Latency, with req first seen in IDLE at cycle t:
  - A write acks at t+2.
  - A read acks at t+2+MEM_LATENCY (t+3 at the default).
  - Back-to-back service is one request per 3 cycles (write) or 3+MEM_LATENCY cycles (read).
- Handshake rule: a requester must drop req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- Non-winner rdata keeps its previous value.
- Losing port: its req stays pending with no ack and is served after the current transaction; it is never dropped.
- Requests that change while busy are ignored until IDLE, because only the values latched in IDLE are used.
- Reset mid-operation: abort on the next edge. State returns to IDLE, enables drop to 0, no ack is issued, last_grant returns to 1, and a pending req is re-arbitrated from IDLE afterwards.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous requests, grant the port not granted last.
  - last_grant updates in IDLE on every grant.
  - After reset, port 0 wins the first contention.
- Undefined:
  - Fixed priority, port 1 always beats port 0.
  - last_grant is still maintained but is unused for selection.

Decomposition:
- Package dsd_mem_pkg holds:
  - state encoding constants ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP (2 bits);
  - port index constants PORT_FETCH=0 and PORT_DATA=1;
  - the default ADDR_W/DATA_W values.
- One combinational sub-module, arb_pick: inputs req[1:0] and last_grant; outputs grant_valid and grant_idx. Its behaviour depends on MEM_MEM_ARB_ROUND_ROBIN_EN, i.e. round robin when MEM_ARB_ROUND_ROBIN_EN is defined and fixed priority when it is not.
- The FSM, latency counter and output registers stay in mem_port_arbiter.

Test Plan:
- Port 0 read: memory preloaded with addr 0x0005=0x1234; p0_req=1, we=0, addr=0x0005 at cycle t -> mem_read_enable=1 only at t+1, p0_ack=1 at t+3 with p0_rdata=0x1234, p1_ack never high.
- Port 1 write followed by port 0 read: p1 writes 0xFFF6 (-10) to 0x0010 -> mem_write_enable for one cycle at t+1, p1_ack at t+2. A following p0 read of 0x0010 returns 0xFFF6.
- Contention without the macro: both ports request reads of 0x0001 and 0x0002 in the same cycle, three times -> port 1 served first each time, port 0 acked afterwards with the correct data, no request lost.
- Contention with MEM_ARB_ROUND_ROBIN_EN: both ports request continuously -> ack order 0,1,0,1. The first grant after reset goes to port 0.
- MEM_LATENCY=3 build: a read of 0x0003 acks at t+5 with correct data, and both enables are 0 throughout WAIT.
- Reset mid-read: assert reset in the WAIT cycle -> next cycle state IDLE, busy=0, enables 0, no ack. Keep p0_req high -> the read re-issues and acks normally after reset is released.
